// File: rtl/conv_pool_out.sv
// conv_pool_out: output stage for the conv_8_4 engine.
// Optional ReLU, 2:1 signed max pooling per frame (an odd tail sample passes
// alone), and a DEPTH-entry {data, last} output FIFO.
// Optional feature macro: CONV_POOL_RELU_EN (clamp inputs to max(x, 0)).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// valid never waits on ready. s_ready_y is derived from registered count
// only. m_data_out_p/m_last_p hold steady while m_valid_p=1 and m_ready_p=0.
module conv_pool_out #(
  parameter int WIDTH     = 18,
  parameter int FRAME_LEN = 5,
  parameter int DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_p,
  output logic                    m_valid_p,
  input  logic                    m_ready_p,
  output logic                    m_last_p,
  output logic                    dbg_state
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {PAIR_A = 1'b0, PAIR_B = 1'b1} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [WIDTH-1:0] hold_q;
  logic                    ready_en_q;

  logic signed [WIDTH-1:0] mem_data [DEPTH];
  logic                    mem_last [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic signed [WIDTH-1:0] last_pop_q;

  logic signed [WIDTH-1:0] x_in;
  logic                    is_tail;
  logic                    in_fire;
  logic                    push;
  logic                    pop;
  logic signed [WIDTH-1:0] push_data;

  // Input conditioning, pairing decision and FIFO push/pop strobes.
  always_comb begin
`ifdef CONV_POOL_RELU_EN
    x_in = (s_data_in_y < 0) ? '0 : s_data_in_y;
`else
    x_in = s_data_in_y;
`endif
    is_tail   = (idx_q == LAST_IDX);
    in_fire   = s_valid_y && s_ready_y;
    push      = in_fire && ((state_q == PAIR_B) || is_tail);
    push_data = x_in;
    if (state_q == PAIR_B) begin
      // Tie keeps the hold value; the result is the same either way.
      push_data = (hold_q >= x_in) ? hold_q : x_in;
    end
    pop = m_valid_p && m_ready_p;
  end

  // Pair state machine: frame index, hold register and pairing state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PAIR_A;
      idx_q   <= '0;
      hold_q  <= '0;
    end else if (in_fire) begin
      idx_q <= is_tail ? '0 : idx_q + 1'b1;
      case (state_q)
        PAIR_A: begin
          if (!is_tail) begin
            hold_q  <= x_in;
            state_q <= PAIR_B;
          end
        end
        PAIR_B: state_q <= PAIR_A;
        default: state_q <= PAIR_A;
      endcase
    end
  end

  // Keeps s_ready_y low during reset and for the release cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // Output FIFO storage, pointers, occupancy and last popped value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_pop_q <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr_q] <= push_data;
        mem_last[wr_ptr_q] <= is_tail;
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_pop_q <= mem_data[rd_ptr_q];
        rd_ptr_q   <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign m_valid_p    = (count_q != '0);
  assign m_data_out_p = m_valid_p ? mem_data[rd_ptr_q] : last_pop_q;
  assign m_last_p     = m_valid_p ? mem_last[rd_ptr_q] : 1'b0;
  assign s_ready_y    = ready_en_q && (count_q < FULL_CNT);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_conv_pool_out.sv
// tb_conv_pool_out: directed bench for conv_pool_out with a frame-level
// pooling model and literal expectations for each directed frame.
module tb_conv_pool_out;

  localparam int W         = 18;
  localparam int FRAME_LEN = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic signed [W-1:0] s_data_in_y;
  logic                s_valid_y;
  logic                s_ready_y;
  logic signed [W-1:0] m_data_out_p;
  logic                m_valid_p;
  logic                m_ready_p;
  logic                m_last_p;
  logic                dbg_state;

  conv_pool_out #(.WIDTH(W), .FRAME_LEN(FRAME_LEN), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
    .m_data_out_p(m_data_out_p), .m_valid_p(m_valid_p), .m_ready_p(m_ready_p),
    .m_last_p(m_last_p), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W:0]          exp_q[$];    // {last, data}
  logic signed [W-1:0] frame_buf[$];
  logic signed [W-1:0] got_d[$];
  logic                got_l[$];
  logic signed [W-1:0] last_pop;
  logic                ready_en;

  function automatic logic signed [W-1:0] cond(input logic signed [W-1:0] x);
`ifdef CONV_POOL_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic model_sample(input logic signed [W-1:0] x);
    int n;
    logic signed [W-1:0] r;
    frame_buf.push_back(cond(x));
    n = frame_buf.size();
    if ((n % 2 == 0) || (n == FRAME_LEN)) begin
      if (n % 2 == 0) r = (frame_buf[n-2] > frame_buf[n-1]) ? frame_buf[n-2] : frame_buf[n-1];
      else            r = frame_buf[n-1];
      exp_q.push_back({(n == FRAME_LEN), r});
    end
    if (n == FRAME_LEN) frame_buf.delete();
  endtask

  // Ready comes up on the first clock edge after reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [W:0] head;
    logic       mdl_ready;
    if (!reset) begin
      exp_q.delete();
      frame_buf.delete();
      last_pop = '0;
      chk("rst_valid", m_valid_p, 0);
      chk("rst_ready", s_ready_y, 0);
      chk("rst_data", m_data_out_p, 0);
      chk("rst_last", m_last_p, 0);
    end else begin
      mdl_ready = ready_en && (exp_q.size() < 2);
      chk("valid", m_valid_p, (exp_q.size() != 0) ? 1 : 0);
      chk("ready", s_ready_y, mdl_ready ? 1 : 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("data", m_data_out_p, $signed(head[W-1:0]));
        chk("last", m_last_p, head[W]);
        if (m_ready_p) begin
          last_pop = head[W-1:0];
          got_d.push_back(head[W-1:0]);
          got_l.push_back(head[W]);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_data", m_data_out_p, last_pop);
        chk("idle_last", m_last_p, 0);
      end
      if (s_valid_y && mdl_ready) model_sample(s_data_in_y);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int v);
    bit ok = 0;
    s_data_in_y = v[W-1:0];
    s_valid_y   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready_y) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1 for sample %0d", v);
    end
    @(posedge clk);
    #1;
    s_valid_y = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic signed [W-1:0] lit_d[6];
  logic                lit_l[6];

  task automatic check_list(input string name, input int n);
    chk({name, "_count"}, got_d.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_d.size()) begin
        chk({name, "_data"}, got_d[i], lit_d[i]);
        chk({name, "_last"}, got_l[i], lit_l[i]);
      end
    end
    got_d.delete();
    got_l.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    s_valid_y   = 1'b0;
    s_data_in_y = '0;
    m_ready_p   = 1'b0;
    #23 reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", s_ready_y, 1);
    chk("idle_after_release", m_valid_p, 0);

    // Mixed-sign frame, no backpressure.
    m_ready_p = 1'b1;
    send(10); send(-3); send(7); send(20); send(-5);
    drain();
`ifdef CONV_POOL_RELU_EN
    lit_d = '{10, 20, 0, 0, 0, 0};
`else
    lit_d = '{10, 20, -5, 0, 0, 0};
`endif
    lit_l = '{0, 0, 1, 0, 0, 0};
    check_list("mixed", 3);

    // All-negative frame.
    send(-100); send(-200); send(-50); send(-60); send(-7);
    drain();
`ifdef CONV_POOL_RELU_EN
    lit_d = '{0, 0, 0, 0, 0, 0};
`else
    lit_d = '{-100, -50, -7, 0, 0, 0};
`endif
    check_list("negative", 3);

    // Backpressure: fill the buffer, stall sample 5, then release.
    m_ready_p = 1'b0;
    send(1); send(2); send(3); send(4);
    @(negedge clk);
    chk("bp_full_ready", s_ready_y, 0);
    chk("bp_valid", m_valid_p, 1);
    chk("bp_head", m_data_out_p, 2);
    fork
      send(5);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_hold_data", m_data_out_p, 2);
          chk("bp_hold_ready", s_ready_y, 0);
        end
        @(posedge clk); #1;
        m_ready_p = 1'b1;
      end
    join
    drain();
    lit_d = '{2, 4, 5, 0, 0, 0};
    check_list("backpressure", 3);

    // Back-to-back frames; idx must wrap between them.
    for (int v = 1; v <= 10; v++) send(v);
    drain();
    lit_d = '{2, 4, 5, 7, 9, 10};
    lit_l = '{0, 0, 1, 0, 0, 1};
    check_list("b2b", 6);

    // Asynchronous reset mid-frame with one result buffered.
    m_ready_p = 1'b0;
    send(1); send(2); send(3);
    chk("pre_rst_valid", m_valid_p, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", m_valid_p, 0);
    chk("async_rst_ready", s_ready_y, 0);
    @(negedge clk); #2 reset = 1'b1;
    got_d.delete();
    got_l.delete();
    @(posedge clk); #1;
    m_ready_p = 1'b1;
    send(3); send(1); send(4); send(1); send(5);
    drain();
    lit_d = '{3, 4, 5, 0, 0, 0};
    lit_l = '{0, 0, 1, 0, 0, 0};
    check_list("post_reset", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
